storage_controller_cached: RTL and testbench

//  Next-gen storage front end between vproc memory bus and external SPI flash. Single-outstanding req/rsp port.

---
 rtl/storage_controller_cached.sv | 222 ++++++++++++++++++++++
 tb/tb_storage_controller_cached.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/storage_controller_cached.sv
// Storage front end: byte-enabled scratchpad, read-only direct-mapped
// flash line cache filled over pipelined wishbone, SPI programming bypass.
// Ports: req_*/rsp_* single-outstanding bus, prog_* mode control,
//   wb_* wishbone master, eng/ext/prog_spi_* pin mux.
module storage_controller_cached #(
  parameter int MEM_W         = 32,
  parameter int SCRATCH_WORDS = 1024,
  parameter int LINE_WORDS    = 4,
  parameter int CACHE_LINES   = 16,
  parameter int FLASH_ADDR_W  = 22,
  parameter int TIMEOUT_CYC   = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [31:0]             req_addr,
  input  logic [MEM_W-1:0]        req_wdata,
  input  logic [MEM_W/8-1:0]      req_be,
  output logic                    rsp_valid,
  output logic [MEM_W-1:0]        rsp_rdata,
  output logic                    rsp_err,
  input  logic                    prog_set,
  input  logic                    prog_clr,
  output logic                    prog_active,
  output logic                    wb_cyc,
  output logic                    wb_stb,
  output logic [FLASH_ADDR_W-1:0] wb_addr,
  input  logic                    wb_stall,
  input  logic                    wb_ack,
  input  logic [MEM_W-1:0]        wb_rdata,
  input  logic                    eng_spi_cs_n,
  input  logic                    eng_spi_sck,
  input  logic                    eng_spi_mosi,
  output logic                    ext_spi_cs_n,
  output logic                    ext_spi_sck,
  output logic                    ext_spi_mosi,
  input  logic                    ext_spi_miso,
  input  logic                    prog_spi_cs_n,
  input  logic                    prog_spi_sck,
  input  logic                    prog_spi_mosi,
  output logic                    prog_spi_miso
);
  localparam int NB    = MEM_W / 8;
  localparam int AB    = $clog2(NB);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(CACHE_LINES);
  localparam int TAG_W = FLASH_ADDR_W - OFF_W - IDX_W;
  localparam int SW_W  = $clog2(SCRATCH_WORDS);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int CW    = CACHE_LINES * LINE_WORDS;
  localparam logic [32:0] SCR_LIM =
    33'(SCRATCH_WORDS) * 33'(NB);

  typedef enum logic [1:0] {
    IDLE, FILL, RESP, PROG
  } state_t;

  state_t state_q, state_d;

  logic [CACHE_LINES-1:0]  valid_q;
  logic                    cyc_q, stb_q;
  logic [FLASH_ADDR_W-1:0] addr_q;
  logic [OFF_W-1:0]        fcnt_q, loff_q;
  logic [IDX_W-1:0]        lidx_q;
  logic [TAG_W-1:0]        ltag_q;
  logic [TMO_W-1:0]        tmo_q;
  logic                    err_q, pend_q;
  logic [MEM_W-1:0]        rdata_q;

  logic [MEM_W-1:0] scratch [SCRATCH_WORDS];
  logic [MEM_W-1:0] cdata   [CW];
  logic [TAG_W-1:0] tag_q   [CACHE_LINES];

  logic [FLASH_ADDR_W-1:0] w_addr;
  logic [OFF_W-1:0]        r_off;
  logic [IDX_W-1:0]        r_idx;
  logic [TAG_W-1:0]        r_tag;
  logic [SW_W-1:0]         s_idx;
  logic is_scr, accept, hit;
  logic fill_ack, last_ack, tmo_hit;

  assign w_addr = req_addr[AB +: FLASH_ADDR_W];
  assign r_off  = w_addr[0 +: OFF_W];
  assign r_idx  = w_addr[OFF_W +: IDX_W];
  assign r_tag  = w_addr[FLASH_ADDR_W-1 -: TAG_W];
  assign s_idx  = req_addr[AB +: SW_W];
  assign is_scr = {1'b0, req_addr} < SCR_LIM;

  assign req_ready = (state_q == IDLE) & ~prog_set;
  assign accept    = req_valid & req_ready;
  assign hit       = valid_q[r_idx] &
                     (tag_q[r_idx] == r_tag);

  assign fill_ack = (state_q == FILL) & cyc_q & wb_ack;
  assign last_ack = fill_ack & (&fcnt_q);
  assign tmo_hit  = (state_q == FILL) & cyc_q & ~wb_ack &
                    (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (prog_set)
          state_d = PROG;
        else if (accept)
          state_d = (~is_scr & ~req_we & ~hit) ?
                    FILL : RESP;
      end
      FILL:
        if (last_ack | tmo_hit) state_d = RESP;
      RESP:
        state_d = (pend_q | prog_set) ? PROG : IDLE;
      PROG:
        if (prog_clr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      addr_q  <= '0;
      fcnt_q  <= '0;
      loff_q  <= '0;
      lidx_q  <= '0;
      ltag_q  <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      // programming request arriving mid-transaction waits for the response
      if ((state_q == FILL || state_q == RESP) && prog_set)
        pend_q <= 1'b1;
      if (state_d == PROG)
        pend_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            err_q   <= 1'b0;
            rdata_q <= '0;
            if (is_scr) begin
              if (!req_we) rdata_q <= scratch[s_idx];
            end else if (req_we) begin
              err_q <= 1'b1;
            end else if (hit) begin
              rdata_q <= cdata[{r_idx, r_off}];
            end else begin
              // line is rewritten in place, so it is invalid until complete
              valid_q[r_idx] <= 1'b0;
              lidx_q <= r_idx;
              loff_q <= r_off;
              ltag_q <= r_tag;
              cyc_q  <= 1'b1;
              stb_q  <= 1'b1;
              addr_q <= {w_addr[FLASH_ADDR_W-1:OFF_W],
                         OFF_W'(0)};
              fcnt_q <= '0;
              tmo_q  <= '0;
            end
          end
        end
        FILL: begin
          if (!cyc_q) begin
            cyc_q <= 1'b1;
            stb_q <= 1'b1;
            tmo_q <= '0;
          end else if (wb_ack) begin
            cyc_q  <= 1'b0;
            stb_q  <= 1'b0;
            fcnt_q <= fcnt_q + 1'b1;
            addr_q <= addr_q + 1'b1;
            if (fcnt_q == loff_q) rdata_q <= wb_rdata;
            if (&fcnt_q) valid_q[lidx_q] <= 1'b1;
          end else if (tmo_hit) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            fcnt_q  <= '0;
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
            if (!wb_stall) stb_q <= 1'b0;
          end
        end
        PROG:
          if (prog_clr) valid_q <= '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept && is_scr && req_we)
      for (int b = 0; b < NB; b++)
        if (req_be[b])
          scratch[s_idx][8*b +: 8] <= req_wdata[8*b +: 8];
    if (fill_ack)
      cdata[{lidx_q, fcnt_q}] <= wb_rdata;
    if (last_ack)
      tag_q[lidx_q] <= ltag_q;
  end

  assign rsp_valid   = (state_q == RESP);
  assign rsp_rdata   = rsp_valid ? rdata_q : '0;
  assign rsp_err     = rsp_valid & err_q;
  assign prog_active = (state_q == PROG);
  assign wb_cyc      = cyc_q;
  assign wb_stb      = stb_q;
  assign wb_addr     = addr_q;

  assign ext_spi_cs_n  = prog_active ? prog_spi_cs_n : eng_spi_cs_n;
  assign ext_spi_sck   = prog_active ? prog_spi_sck  : eng_spi_sck;
  assign ext_spi_mosi  = prog_active ? prog_spi_mosi : eng_spi_mosi;
  assign prog_spi_miso = prog_active ? ext_spi_miso  : 1'b1;
endmodule

// File: tb/tb_storage_controller_cached.sv
// Bench for storage_controller_cached: directed vector table plus
// hand sequences for fills, stalls, timeout, programming and reset.
module tb_storage_controller_cached;
  localparam int TMO = 4096;

  logic clk, rst;
  logic req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic prog_set, prog_clr, prog_active;
  logic wb_cyc, wb_stb, wb_stall, wb_ack;
  logic [21:0] wb_addr;
  logic [31:0] wb_rdata;
  logic eng_cs, eng_sck, eng_mosi;
  logic ext_cs, ext_sck, ext_mosi, ext_miso;
  logic pg_cs, pg_sck, pg_mosi, pg_miso;

  storage_controller_cached dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .prog_set(prog_set), .prog_clr(prog_clr),
    .prog_active(prog_active),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_addr(wb_addr),
    .wb_stall(wb_stall), .wb_ack(wb_ack),
    .wb_rdata(wb_rdata),
    .eng_spi_cs_n(eng_cs), .eng_spi_sck(eng_sck),
    .eng_spi_mosi(eng_mosi),
    .ext_spi_cs_n(ext_cs), .ext_spi_sck(ext_sck),
    .ext_spi_mosi(ext_mosi), .ext_spi_miso(ext_miso),
    .prog_spi_cs_n(pg_cs), .prog_spi_sck(pg_sck),
    .prog_spi_mosi(pg_mosi), .prog_spi_miso(pg_miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] fdata(input logic [21:0] a);
    return {10'h2B5, a};
  endfunction

  // wishbone slave model: registered, acks the cycle after acceptance
  int cycle = 0;
  int cyc_cnt = 0;
  int stall_seen = 0;
  int stall_mark = 0;
  int last_ack_cyc = 0;
  logic stall_on = 1'b0;
  logic [21:0] stall_addr = '0;
  logic ack_dis = 1'b0;
  logic [21:0] acc_q [$];

  assign wb_stall = stall_on && (stall_seen - stall_mark < 3) &&
                    wb_cyc && wb_stb && (wb_addr == stall_addr);

  initial begin
    wb_ack = 1'b0;
    wb_rdata = '0;
  end

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (wb_cyc) cyc_cnt <= cyc_cnt + 1;
    if (wb_stall) stall_seen <= stall_seen + 1;
    wb_ack <= 1'b0;
    if (wb_cyc && wb_stb && !wb_stall && !ack_dis) begin
      wb_ack <= 1'b1;
      wb_rdata <= fdata(wb_addr);
      acc_q.push_back(wb_addr);
    end
  end

  always @(negedge clk)
    if (wb_ack) last_ack_cyc = cycle;

  task automatic do_req(input logic we,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [3:0] be,
                        output logic [31:0] rd,
                        output logic er,
                        output int lat,
                        output int rc);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we = we;
    req_addr = a;
    req_wdata = d;
    req_be = be;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("ready_wait", {31'b0, req_ready}, 1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 6000) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) chk("rsp_wait", {31'b0, rsp_valid}, 1);
    rd = rsp_rdata;
    er = rsp_err;
    rc = cycle;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tv [9];
  logic [31:0] rd;
  logic er;
  int lat, rc, c0, a0, s0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tv[0] = '{1'b1, 32'h10,   32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0};
    tv[1] = '{1'b1, 32'h10,   32'h0000_3C00, 4'h2, 32'h0, 1'b0};
    tv[2] = '{1'b0, 32'h10,   32'h0,         4'h0, 32'hA5A5_3CA5, 1'b0};
    tv[3] = '{1'b0, 32'h13,   32'h0,         4'h0, 32'hA5A5_3CA5, 1'b0};
    tv[4] = '{1'b1, 32'hFFC,  32'h1234_5678, 4'hF, 32'h0, 1'b0};
    tv[5] = '{1'b1, 32'hFFC,  32'hDEAD_0000, 4'hC, 32'h0, 1'b0};
    tv[6] = '{1'b0, 32'hFFC,  32'h0,         4'h0, 32'hDEAD_5678, 1'b0};
    tv[7] = '{1'b1, 32'h2000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1};
    tv[8] = '{1'b1, 32'h1000, 32'h1111_1111, 4'hF, 32'h0, 1'b1};

    rst = 1'b0;
    req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0;
    prog_set = 1'b0; prog_clr = 1'b0;
    eng_cs = 1'b1; eng_sck = 1'b0; eng_mosi = 1'b1;
    pg_cs = 1'b0; pg_sck = 1'b1; pg_mosi = 1'b0;
    ext_miso = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_cyc_stb", {30'b0, wb_cyc, wb_stb}, 0);
    chk("rst_wb_addr", {10'b0, wb_addr}, 0);
    chk("rst_prog_active", {31'b0, prog_active}, 0);
    chk("rst_ext_spi", {29'b0, ext_cs, ext_sck, ext_mosi}, 3'b101);
    chk("rst_prog_miso", {31'b0, pg_miso}, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 1);

    c0 = cyc_cnt;
    for (int i = 0; i < 9; i++) begin
      do_req(tv[i].we, tv[i].addr, tv[i].wdata, tv[i].be,
             rd, er, lat, rc);
      chk($sformatf("vec%0d_rdata", i), rd, tv[i].exp_rd);
      chk($sformatf("vec%0d_err", i), {31'b0, er},
          {31'b0, tv[i].exp_err});
      chk($sformatf("vec%0d_lat", i), lat, 1);
    end
    chk("vec_no_wb", cyc_cnt - c0, 0);

    a0 = acc_q.size();
    do_req(1'b0, 32'h1010, '0, '0, rd, er, lat, rc);
    chk("cold_rdata", rd, fdata(22'h404));
    chk("cold_err", {31'b0, er}, 0);
    chk("cold_lat", rc, last_ack_cyc + 1);
    chk("cold_cnt", acc_q.size() - a0, 4);
    for (int i = 0; i < 4 && a0 + i < acc_q.size(); i++)
      chk($sformatf("cold_order%0d", i),
          {10'b0, acc_q[a0+i]}, 32'h404 + i);

    c0 = cyc_cnt;
    do_req(1'b0, 32'h1010, '0, '0, rd, er, lat, rc);
    chk("hit_rdata", rd, fdata(22'h404));
    chk("hit_lat", lat, 1);
    do_req(1'b0, 32'h101C, '0, '0, rd, er, lat, rc);
    chk("hit3_rdata", rd, fdata(22'h407));
    chk("hit_no_wb", cyc_cnt - c0, 0);

    stall_mark = stall_seen;
    stall_addr = 22'h80A;
    stall_on = 1'b1;
    a0 = acc_q.size();
    do_req(1'b0, 32'h2024, '0, '0, rd, er, lat, rc);
    stall_on = 1'b0;
    chk("stall_cycles", stall_seen - stall_mark, 3);
    chk("stall_rdata", rd, fdata(22'h809));
    chk("stall_cnt", acc_q.size() - a0, 4);
    for (int i = 0; i < 4 && a0 + i < acc_q.size(); i++)
      chk($sformatf("stall_order%0d", i),
          {10'b0, acc_q[a0+i]}, 32'h808 + i);

    ack_dis = 1'b1;
    a0 = acc_q.size();
    do_req(1'b0, 32'h3030, '0, '0, rd, er, lat, rc);
    chk("tmo_err", {31'b0, er}, 1);
    chk("tmo_rdata", rd, 0);
    chk("tmo_cyc_low", {31'b0, wb_cyc}, 0);
    chk("tmo_lat", {31'b0, lat >= TMO && lat <= TMO + 2}, 1);
    ack_dis = 1'b0;
    do_req(1'b0, 32'h3030, '0, '0, rd, er, lat, rc);
    chk("retry_err", {31'b0, er}, 0);
    chk("retry_rdata", rd, fdata(22'hC0C));
    chk("retry_cnt", acc_q.size() - a0, 4);
    if (acc_q.size() > a0)
      chk("retry_first", {10'b0, acc_q[a0]}, 32'hC0C);

    fork
      do_req(1'b0, 32'h4040, '0, '0, rd, er, lat, rc);
      begin
        s0 = 0;
        while (!wb_cyc && s0 < 50) begin
          @(negedge clk);
          s0++;
        end
        @(negedge clk);
        prog_set = 1'b1;
        @(negedge clk);
        prog_set = 1'b0;
      end
    join
    chk("pfill_rdata", rd, fdata(22'h1010));
    chk("pfill_err", {31'b0, er}, 0);
    chk("pfill_not_yet", {31'b0, prog_active}, 0);
    @(negedge clk);
    chk("pfill_prog", {31'b0, prog_active}, 1);
    chk("prog_ready", {31'b0, req_ready}, 0);
    #1;
    chk("prog_ext", {29'b0, ext_cs, ext_sck, ext_mosi}, 3'b010);
    chk("prog_miso0", {31'b0, pg_miso}, 0);
    ext_miso = 1'b1;
    pg_cs = 1'b1; pg_sck = 1'b0; pg_mosi = 1'b1;
    eng_cs = 1'b0; eng_sck = 1'b1; eng_mosi = 1'b0;
    #1;
    chk("prog_ext2", {29'b0, ext_cs, ext_sck, ext_mosi}, 3'b101);
    chk("prog_miso1", {31'b0, pg_miso}, 1);
    ext_miso = 1'b0;
    @(negedge clk);
    prog_clr = 1'b1;
    @(negedge clk);
    prog_clr = 1'b0;
    chk("clr_idle", {31'b0, prog_active}, 0);
    chk("clr_eng", {29'b0, ext_cs, ext_sck, ext_mosi}, 3'b010);
    a0 = acc_q.size();
    do_req(1'b0, 32'h1010, '0, '0, rd, er, lat, rc);
    chk("flush_miss", acc_q.size() - a0, 4);
    chk("flush_rdata", rd, fdata(22'h404));

    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    prog_set = 1'b1;
    #1;
    chk("beat_ready", {31'b0, req_ready}, 0);
    @(negedge clk);
    chk("beat_prog", {31'b0, prog_active}, 1);
    chk("beat_no_rsp", {31'b0, rsp_valid}, 0);
    req_valid = 1'b0;
    prog_clr = 1'b1;
    @(negedge clk);
    chk("both_clr_wins", {31'b0, prog_active}, 0);
    prog_set = 1'b0;
    prog_clr = 1'b0;
    @(negedge clk);
    prog_clr = 1'b1;
    @(negedge clk);
    prog_clr = 1'b0;
    chk("clr_ignored", {31'b0, prog_active}, 0);
    chk("clr_ign_ready", {31'b0, req_ready}, 1);

    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h5050;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstfill_cyc", {31'b0, wb_cyc}, 0);
    @(negedge clk);
    rst = 1'b1;
    a0 = acc_q.size();
    do_req(1'b0, 32'h5050, '0, '0, rd, er, lat, rc);
    chk("rstfill_miss", acc_q.size() - a0, 4);
    chk("rstfill_rdata", rd, fdata(22'h1414));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
